// File: rtl/tick_scheduler_pkg.sv
// Shared types for the tick scheduler: event FSM states, per-channel configuration
// record and a small round-robin index helper.
package tick_scheduler_pkg;

  // The period field is sized for the widest divider we support; narrower
  // instances zero-extend into it and only compare the low DIV_WIDTH bits.
  localparam int MAX_DIV_WIDTH = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } fsm_state_t;

  typedef struct packed {
    logic [MAX_DIV_WIDTH-1:0] period;
    logic                     enable;
    logic                     oneshot;
  } chan_cfg_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/tick_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or above
// ptr, wrapping past the top channel back to channel 0.
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int CH_BITS  = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CH_BITS-1:0]  ptr,
  output logic                gnt_valid,
  output logic [CHANNELS-1:0] gnt_onehot,
  output logic [CH_BITS-1:0]  gnt_idx
);

  logic [CH_BITS-1:0] j;

  // Walk from the farthest offset down so the nearest request is written last.
  always_comb begin
    gnt_valid  = 1'b0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    j          = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      j = CH_BITS'((int'(ptr) + k) % CHANNELS);
      if (req[j]) begin
        gnt_valid  = 1'b1;
        gnt_onehot = '0;
        gnt_onehot[j] = 1'b1;
        gnt_idx    = j;
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Divides a shared base tick into CHANNELS programmable timers and serialises
// their expiries onto one valid/ready event port through a round-robin arbiter.
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int  CHANNELS  = 4,
  parameter int  DIV_WIDTH = 8,
  localparam int CH_BITS   = $clog2(CHANNELS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick_in,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_BITS-1:0]   cfg_chan,
  input  logic [DIV_WIDTH-1:0] cfg_period,
  input  logic                 cfg_enable,
  input  logic                 cfg_oneshot,
  output logic                 event_valid,
  output logic [CH_BITS-1:0]   event_chan,
  input  logic                 event_ready,
  output logic [CHANNELS-1:0]  overrun
);

  logic                cfg_accept;
  logic [CHANNELS-1:0] cfg_hit;
  logic [CHANNELS-1:0] fire;
  logic [CHANNELS-1:0] pending_q;
  logic [CHANNELS-1:0] overrun_q;
  logic [CHANNELS-1:0] pend_kept;
  logic [CH_BITS-1:0]  rr_ptr_q;
  logic [CH_BITS-1:0]  event_chan_q;
  fsm_state_t          state_q, state_d;
  logic                load;
  logic                release_ev;
  logic                gnt_valid;
  logic [CHANNELS-1:0] gnt_onehot;
  logic [CH_BITS-1:0]  gnt_idx;

  assign cfg_ready  = ~reset;
  assign cfg_accept = cfg_valid && cfg_ready;

  // Per-channel divider. A config write to a channel overrides its tick in the
  // same cycle, so the expiry is suppressed and the count restarts from zero.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    chan_cfg_t            cfg_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] per;
    logic                 active;
    logic                 wrap;

    assign cfg_hit[i] = cfg_accept && (cfg_chan == CH_BITS'(i));
    assign per        = cfg_q.period[DIV_WIDTH-1:0];
    assign active     = tick_in && cfg_q.enable && (cfg_q.period != '0);
    assign wrap       = (cnt_q == per - DIV_WIDTH'(1));
    assign fire[i]    = active && wrap && !cfg_hit[i];

    always_ff @(posedge clock) begin
      if (reset) begin
        cfg_q <= '0;
        cnt_q <= '0;
      end else if (cfg_hit[i]) begin
        cfg_q <= '{period:  MAX_DIV_WIDTH'(cfg_period),
                   enable:  cfg_enable,
                   oneshot: cfg_oneshot};
        cnt_q <= '0;
      end else if (active) begin
        if (wrap) begin
          cnt_q <= '0;
          if (cfg_q.oneshot) cfg_q.enable <= 1'b0;
        end else begin
          cnt_q <= cnt_q + DIV_WIDTH'(1);
        end
      end
    end
  end

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .CH_BITS  (CH_BITS)
  ) u_arb (
    .req        (pending_q),
    .ptr        (rr_ptr_q),
    .gnt_valid  (gnt_valid),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx)
  );

  // Event FSM: state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Event FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_valid)   state_d = PRESENT;
      PRESENT: if (event_ready) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Event FSM: outputs
  always_comb begin
    load       = 1'b0;
    release_ev = 1'b0;
    unique case (state_q)
      IDLE:    load       = gnt_valid;
      PRESENT: release_ev = event_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      event_chan_q <= '0;
      rr_ptr_q     <= '0;
    end else if (load) begin
      event_chan_q <= gnt_idx;
      rr_ptr_q     <= CH_BITS'(rr_next(int'(gnt_idx), CHANNELS));
    end
  end

  // A pending bit consumed by this cycle's load is free to take a new fire,
  // so only bits still held afterwards can turn a fire into an overrun.
  assign pend_kept = pending_q & ~(load ? gnt_onehot : '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      pending_q <= (pend_kept | fire) & ~cfg_hit;
      overrun_q <= (overrun_q | (pend_kept & fire)) & ~cfg_hit;
    end
  end

  assign event_valid = (state_q == PRESENT);
  assign event_chan  = event_chan_q;
  assign overrun     = overrun_q;

  logic unused_release;
  assign unused_release = release_ev;

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: a behavioural model queues expected events,
// a monitor compares every presented event and the overrun flags.
module tb_tick_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick_in;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_chan;
  logic [7:0] cfg_period;
  logic       cfg_enable;
  logic       cfg_oneshot;
  logic       event_valid;
  logic [1:0] event_chan;
  logic       event_ready;
  logic [3:0] overrun;

  tick_scheduler #(.CHANNELS(4), .DIV_WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .tick_in     (tick_in),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_chan    (cfg_chan),
    .cfg_period  (cfg_period),
    .cfg_enable  (cfg_enable),
    .cfg_oneshot (cfg_oneshot),
    .event_valid (event_valid),
    .event_chan  (event_chan),
    .event_ready (event_ready),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int n_events = 0;
  int exp_q[$];
  int got_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: timers count ticks, expiries set a pending flag per
  // channel, and a single presenter hands them out one at a time starting
  // the search after the last channel served.
  int  m_per[4];
  bit  m_en[4];
  bit  m_os[4];
  int  m_cnt[4];
  bit  m_pend[4];
  bit  m_ovr[4];
  bit  m_busy;
  int  m_chan;
  int  m_rr;

  always @(posedge clock) begin : model
    bit was_busy;
    bit fired;
    int c;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_per[i] = 0; m_en[i] = 0; m_os[i] = 0; m_cnt[i] = 0;
        m_pend[i] = 0; m_ovr[i] = 0;
      end
      m_busy = 0; m_chan = 0; m_rr = 0;
      exp_q.delete();
    end else begin
      was_busy = m_busy;
      if (m_busy && event_ready) m_busy = 0;
      if (!was_busy) begin
        for (int k = 0; k < 4; k++) begin
          c = (m_rr + k) % 4;
          if (m_pend[c]) begin
            m_pend[c] = 0;
            m_chan = c;
            m_busy = 1;
            m_rr = (c + 1) % 4;
            exp_q.push_back(c);
            break;
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        fired = 0;
        if (cfg_valid && int'(cfg_chan) == i) begin
          m_per[i] = int'(cfg_period); m_en[i] = cfg_enable; m_os[i] = cfg_oneshot;
          m_cnt[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
        end else if (tick_in && m_en[i] && m_per[i] != 0) begin
          m_cnt[i] = m_cnt[i] + 1;
          if (m_cnt[i] == m_per[i]) begin
            m_cnt[i] = 0;
            fired = 1;
            if (m_os[i]) m_en[i] = 0;
          end
        end
        if (fired) begin
          if (m_pend[i]) m_ovr[i] = 1;
          else           m_pend[i] = 1;
        end
      end
    end
  end

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clock) begin : monitor
    logic [3:0] ov;
    int e;
    if (!reset) begin
      for (int i = 0; i < 4; i++) ov[i] = m_ovr[i];
      check("overrun", int'(overrun), int'(ov));
      check("event_valid", int'(event_valid), int'(m_busy));
      if (event_valid) check("event_chan_hold", int'(event_chan), m_chan);
      if (event_valid && event_ready) begin
        n_events++;
        got_q.push_back(int'(event_chan));
        if (exp_q.size() == 0) begin
          check("unexpected_event", int'(event_chan), -1);
        end else begin
          e = exp_q.pop_front();
          check("event_order", int'(event_chan), e);
        end
      end
    end
  end

  task automatic cyc(input bit t, input bit cv = 0, input int ch = 0, input int p = 0,
                     input bit en = 0, input bit os = 0);
    tick_in     = t;
    cfg_valid   = cv;
    cfg_chan    = 2'(ch);
    cfg_period  = 8'(p);
    cfg_enable  = en;
    cfg_oneshot = os;
    @(posedge clock); #1;
    tick_in   = 0;
    cfg_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0);
  endtask

  task automatic ticks(input int n, input int gap);
    repeat (n) begin
      cyc(1);
      idle(gap - 1);
    end
  endtask

  task automatic cfg(input int ch, input int p, input bit en, input bit os);
    cyc(0, 1, ch, p, en, os);
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    repeat (n) begin
      @(posedge clock); #1;
    end
    reset = 0;
  endtask

  int base;

  initial begin
    reset = 1; tick_in = 0; cfg_valid = 0; cfg_chan = 0; cfg_period = 0;
    cfg_enable = 0; cfg_oneshot = 0; event_ready = 1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_cfg_ready", int'(cfg_ready), 0);
    check("reset_event_valid", int'(event_valid), 0);
    check("reset_event_chan", int'(event_chan), 0);
    check("reset_overrun", int'(overrun), 0);
    reset = 0;
    #1;
    check("cfg_ready_after_reset", int'(cfg_ready), 1);

    // Periodic P=3: expiries on ticks 3, 6 and 9 of 11.
    cfg(0, 3, 1, 0);
    base = n_events;
    ticks(11, 4);
    idle(5);
    check("periodic_p3_count", n_events - base, 3);

    // One-shot P=2: exactly one expiry in six ticks.
    cfg(0, 0, 0, 0);
    cfg(1, 2, 1, 1);
    base = n_events;
    ticks(6, 4);
    idle(5);
    check("oneshot_count", n_events - base, 1);

    // Three simultaneous expiries, twice; order must restart at channel 0.
    do_reset(2);
    cfg(0, 1, 1, 0);
    cfg(1, 1, 1, 0);
    cfg(2, 1, 1, 0);
    got_q.delete();
    ticks(1, 10);
    ticks(1, 10);
    check("rr_count", got_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < got_q.size()) check("rr_order", got_q[i], i % 3);
    end
    cfg(0, 0, 0, 0);
    cfg(1, 0, 0, 0);
    cfg(2, 0, 0, 0);

    // Back-pressure: held event, re-pending, then overrun.
    cfg(3, 1, 1, 0);
    base = n_events;
    event_ready = 0;
    ticks(3, 4);
    check("held_valid", int'(event_valid), 1);
    check("held_chan", int'(event_chan), 3);
    check("overrun_ch3", int'(overrun), 4'b1000);
    event_ready = 1;
    idle(6);
    check("backpressure_count", n_events - base, 2);
    cfg(3, 0, 0, 0);
    check("overrun_cleared", int'(overrun), 0);

    // Config write colliding with the expiring tick wins.
    cfg(0, 2, 1, 0);
    ticks(1, 4);
    base = n_events;
    cyc(1, 1, 0, 5, 1, 0);
    idle(4);
    check("collide_no_event", n_events - base, 0);
    ticks(4, 4);
    check("p5_early", n_events - base, 0);
    ticks(1, 4);
    check("p5_fire", n_events - base, 1);

    // Reset while presenting drops everything.
    cfg(2, 1, 1, 0);
    event_ready = 0;
    ticks(3, 4);
    reset = 1;
    @(posedge clock); #1;
    check("midreset_valid", int'(event_valid), 0);
    check("midreset_overrun", int'(overrun), 0);
    @(posedge clock); #1;
    reset = 0;
    event_ready = 1;
    base = n_events;
    ticks(5, 4);
    check("after_reset_silent", n_events - base, 0);

    // Randomised traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      int sel;
      int p;
      event_ready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 999) == 0) begin
        do_reset(1);
      end else if ($urandom_range(0, 19) == 0) begin
        sel = $urandom_range(0, 5);
        case (sel)
          0: p = 0;
          1: p = 1;
          2: p = 2;
          3: p = 255;
          default: p = $urandom_range(1, 7);
        endcase
        cyc($urandom_range(0, 2) == 0, 1, $urandom_range(0, 3), p,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      end else begin
        cyc($urandom_range(0, 2) == 0);
      end
    end

    // Drain.
    event_ready = 1;
    for (int i = 0; i < 4; i++) cfg(i, 0, 0, 0);
    idle(20);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_idle", int'(event_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
